// File: rtl/clock_pkg.sv
// Shared definitions for the alarm controller:
// FSM state encoding and default timing parameters.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_RING   = 2'd2,
        ST_SNOOZE = 2'd3
    } alarm_st_e;

    localparam int SNOOZE_SEC_D       = 300;
    localparam int RING_TIMEOUT_SEC_D = 60;
    localparam int MAX_SNOOZE_D       = 3;
    localparam int REPEAT_DLY_D       = 5;

endpackage

// File: rtl/btn_autorepeat.sv
// Held-button increment generator: one pulse on press,
// then one per tick once the repeat delay has elapsed.
module btn_autorepeat
    import clock_pkg::*;
#(
    parameter int REPEAT_DLY = REPEAT_DLY_D
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_btn,
    input  logic i_tick,
    output logic o_pulse
);

    localparam logic [7:0] L_DLY = 8'(REPEAT_DLY);

    logic       r_live;
    logic       r_prev;
    logic       r_held;
    logic       r_pulse;
    logic [7:0] r_dly;
    logic       w_press;

    // r_live masks the first cycle after reset so a held button
    // does not look like a fresh press on release of reset.
    assign w_press = r_live & i_btn & ~r_prev;
    assign o_pulse = r_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live  <= 1'b0;
            r_prev  <= 1'b0;
            r_held  <= 1'b0;
            r_pulse <= 1'b0;
            r_dly   <= 8'd0;
        end else begin
            r_live  <= 1'b1;
            r_prev  <= i_btn;
            r_pulse <= 1'b0;
            if (!i_en || !i_btn) begin
                r_held <= 1'b0;
                r_dly  <= 8'd0;
            end else if (w_press) begin
                r_held  <= 1'b1;
                r_dly   <= 8'd0;
                r_pulse <= 1'b1;
            end else if (r_held && i_tick) begin
                if (r_dly < L_DLY) begin
                    r_dly <= r_dly + 8'd1;
                end else begin
                    r_pulse <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: arm/ring/snooze sequencing, buzzer cadence
// and alarm-time set buttons with auto-repeat.
module alarm_ctrl
    import clock_pkg::*;
#(
    parameter int SNOOZE_SEC       = SNOOZE_SEC_D,
    parameter int RING_TIMEOUT_SEC = RING_TIMEOUT_SEC_D,
    parameter int MAX_SNOOZE       = MAX_SNOOZE_D,
    parameter int REPEAT_DLY       = REPEAT_DLY_D
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_10hz,
    input  logic       sw_alarm_enable,
    input  logic       alarm_on,
    input  logic       btn_snooze,
    input  logic       btn_stop,
    input  logic       set_mode,
    input  logic       btn_set_hour,
    input  logic       btn_set_min,
    output logic       alarm_enable,
    output logic       alarm_clear,
    output logic       inc_alarm_hour,
    output logic       inc_alarm_min,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic [8:0] snooze_left
);

    localparam logic [8:0]  L_SNZ = 9'(SNOOZE_SEC);
    localparam logic [15:0] L_TMO = 16'(RING_TIMEOUT_SEC - 1);
    localparam logic [7:0]  L_MAX = 8'(MAX_SNOOZE);

    alarm_st_e   r_state;
    alarm_st_e   w_next;
    logic [15:0] r_ring_cnt;
    logic [15:0] w_ring_nx;
    logic [3:0]  r_beep;
    logic [3:0]  w_beep_nx;
    logic [7:0]  r_snz_cnt;
    logic [7:0]  w_cnt_nx;
    logic [8:0]  r_snz_left;
    logic [8:0]  w_left_nx;
    logic        w_clear;
    logic        w_ring_stop;
    logic        w_set_en;

    logic r_alarm_en;
    logic r_clear;
    logic r_buzzer;
    logic r_ringing;
    logic r_snoozing;

    // Exhausted snoozes and the ring timeout both behave as a stop.
    assign w_ring_stop = btn_stop
                       | (btn_snooze & (r_snz_cnt >= L_MAX))
                       | (tick_1hz & (r_ring_cnt == L_TMO));

    always_comb begin
        w_next    = r_state;
        w_clear   = 1'b0;
        w_ring_nx = r_ring_cnt;
        w_beep_nx = r_beep;
        w_cnt_nx  = r_snz_cnt;
        w_left_nx = r_snz_left;
        if (!sw_alarm_enable) begin
            w_next    = ST_IDLE;
            w_clear   = (r_state == ST_RING) | (r_state == ST_SNOOZE);
            w_cnt_nx  = 8'd0;
            w_left_nx = 9'd0;
        end else begin
            unique case (r_state)
                ST_IDLE: w_next = ST_ARMED;
                ST_ARMED: begin
                    if (alarm_on) w_next = ST_RING;
                end
                ST_RING: begin
                    if (w_ring_stop) begin
                        w_next   = ST_ARMED;
                        w_clear  = 1'b1;
                        w_cnt_nx = 8'd0;
                    end else if (btn_snooze) begin
                        w_next    = ST_SNOOZE;
                        w_clear   = 1'b1;
                        w_cnt_nx  = r_snz_cnt + 8'd1;
                        w_left_nx = L_SNZ;
                    end else begin
                        if (tick_1hz) w_ring_nx = r_ring_cnt + 16'd1;
                        if (tick_10hz) begin
                            w_beep_nx = (r_beep == 4'd9) ? 4'd0
                                                         : r_beep + 4'd1;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (btn_stop) begin
                        w_next    = ST_ARMED;
                        w_cnt_nx  = 8'd0;
                        w_left_nx = 9'd0;
                    end else if (tick_1hz) begin
                        if (r_snz_left <= 9'd1) begin
                            w_next    = ST_RING;
                            w_left_nx = 9'd0;
                        end else begin
                            w_left_nx = r_snz_left - 9'd1;
                        end
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
        if (w_next == ST_RING && r_state != ST_RING) begin
            w_ring_nx = 16'd0;
            w_beep_nx = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ring_cnt <= 16'd0;
            r_beep     <= 4'd0;
            r_snz_cnt  <= 8'd0;
            r_snz_left <= 9'd0;
            r_alarm_en <= 1'b0;
            r_clear    <= 1'b0;
            r_buzzer   <= 1'b0;
            r_ringing  <= 1'b0;
            r_snoozing <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_ring_cnt <= w_ring_nx;
            r_beep     <= w_beep_nx;
            r_snz_cnt  <= w_cnt_nx;
            r_snz_left <= w_left_nx;
            r_alarm_en <= (w_next != ST_IDLE);
            r_clear    <= w_clear;
            r_buzzer   <= (w_next == ST_RING) & (w_beep_nx < 4'd5);
            r_ringing  <= (w_next == ST_RING);
            r_snoozing <= (w_next == ST_SNOOZE);
        end
    end

    // Gating on the next state too keeps a pulse from landing in RINGING.
    assign w_set_en = set_mode & (r_state != ST_RING) & (w_next != ST_RING);

    btn_autorepeat #(.REPEAT_DLY(REPEAT_DLY)) u_rep_hour (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_set_en),
        .i_btn   (btn_set_hour),
        .i_tick  (tick_10hz),
        .o_pulse (inc_alarm_hour)
    );

    btn_autorepeat #(.REPEAT_DLY(REPEAT_DLY)) u_rep_min (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_set_en),
        .i_btn   (btn_set_min),
        .i_tick  (tick_10hz),
        .o_pulse (inc_alarm_min)
    );

    assign alarm_enable = r_alarm_en;
    assign alarm_clear  = r_clear;
    assign buzzer       = r_buzzer;
    assign ringing      = r_ringing;
    assign snoozing     = r_snoozing;
    assign snooze_left  = r_snz_left;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: directed scenarios plus random stimulus,
// every cycle compared against a behavioural model.
module tb_alarm_ctrl;

    localparam int SNZ  = 3;
    localparam int TMO  = 5;
    localparam int MAXS = 2;
    localparam int RDLY = 5;

    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_RING = 2;
    localparam int M_SNZ  = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1hz = 1'b0;
    logic       tick_10hz = 1'b0;
    logic       sw_alarm_enable = 1'b0;
    logic       alarm_on = 1'b0;
    logic       btn_snooze = 1'b0;
    logic       btn_stop = 1'b0;
    logic       set_mode = 1'b0;
    logic       btn_set_hour = 1'b0;
    logic       btn_set_min = 1'b0;
    logic       alarm_enable;
    logic       alarm_clear;
    logic       inc_alarm_hour;
    logic       inc_alarm_min;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic [8:0] snooze_left;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alarm_ctrl #(
        .SNOOZE_SEC(SNZ), .RING_TIMEOUT_SEC(TMO),
        .MAX_SNOOZE(MAXS), .REPEAT_DLY(RDLY)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .tick_1hz(tick_1hz), .tick_10hz(tick_10hz),
        .sw_alarm_enable(sw_alarm_enable), .alarm_on(alarm_on),
        .btn_snooze(btn_snooze), .btn_stop(btn_stop),
        .set_mode(set_mode), .btn_set_hour(btn_set_hour),
        .btn_set_min(btn_set_min), .alarm_enable(alarm_enable),
        .alarm_clear(alarm_clear), .inc_alarm_hour(inc_alarm_hour),
        .inc_alarm_min(inc_alarm_min), .buzzer(buzzer),
        .ringing(ringing), .snoozing(snoozing),
        .snooze_left(snooze_left)
    );

    // Model: mode, seconds/tenths rung since entry, snoozes used.
    int m_md, m_secs, m_tenths, m_snz_n, m_left;
    bit m_clr, m_live;
    int m_hold [2];
    bit m_prev [2];
    bit m_held [2];
    bit m_pulse [2];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] dut_outs();
        return {alarm_enable, alarm_clear, inc_alarm_hour, inc_alarm_min,
                buzzer, ringing, snoozing, snooze_left};
    endfunction

    function automatic logic [15:0] exp_outs();
        logic bz;
        bz = (m_md == M_RING) && (((m_tenths / 5) % 2) == 0);
        return {m_md != M_IDLE, m_clr, m_pulse[0], m_pulse[1], bz,
                m_md == M_RING, m_md == M_SNZ, 9'(m_left)};
    endfunction

    task automatic model_reset();
        m_md = M_IDLE; m_secs = 0; m_tenths = 0; m_snz_n = 0;
        m_left = 0; m_clr = 0; m_live = 0;
        for (int c = 0; c < 2; c++) begin
            m_hold[c] = 0; m_prev[c] = 0; m_held[c] = 0; m_pulse[c] = 0;
        end
    endtask

    task automatic model_step();
        int nm;
        bit clr;
        bit en;
        bit b [2];
        nm = m_md;
        clr = 0;
        if (!sw_alarm_enable) begin
            nm = M_IDLE;
            clr = (m_md == M_RING) || (m_md == M_SNZ);
            m_snz_n = 0;
            m_left = 0;
        end else if (m_md == M_IDLE) begin
            nm = M_ARM;
        end else if (m_md == M_ARM) begin
            if (alarm_on) nm = M_RING;
        end else if (m_md == M_RING) begin
            if (btn_stop || (btn_snooze && m_snz_n == MAXS)
                || (tick_1hz && m_secs + 1 == TMO)) begin
                nm = M_ARM; clr = 1; m_snz_n = 0;
            end else if (btn_snooze) begin
                nm = M_SNZ; clr = 1; m_snz_n++; m_left = SNZ;
            end else begin
                m_secs += int'(tick_1hz);
                m_tenths += int'(tick_10hz);
            end
        end else begin
            if (btn_stop) begin
                nm = M_ARM; m_snz_n = 0; m_left = 0;
            end else if (tick_1hz) begin
                m_left--;
                if (m_left == 0) nm = M_RING;
            end
        end
        if (nm == M_RING && m_md != M_RING) begin
            m_secs = 0;
            m_tenths = 0;
        end
        en = set_mode && m_md != M_RING && nm != M_RING;
        b[0] = btn_set_hour;
        b[1] = btn_set_min;
        for (int c = 0; c < 2; c++) begin
            if (!en || !b[c]) begin
                m_held[c] = 0; m_pulse[c] = 0;
            end else if (m_live && !m_prev[c]) begin
                m_held[c] = 1; m_hold[c] = 0; m_pulse[c] = 1;
            end else if (m_held[c] && tick_10hz) begin
                m_hold[c]++;
                m_pulse[c] = (m_hold[c] > RDLY);
            end else begin
                m_pulse[c] = 0;
            end
            m_prev[c] = b[c];
        end
        m_live = 1;
        m_md = nm;
        m_clr = clr;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        check("outs", 32'(dut_outs()), 32'(exp_outs()));
        tick_1hz = 0; tick_10hz = 0; btn_stop = 0; btn_snooze = 0;
    endtask

    task automatic async_reset();
        #2 rst_n = 0;
        model_reset();
        #1 check("arst_outs", 32'(dut_outs()), 32'd0);
        step();
        rst_n = 1;
    endtask

    int cnt;

    initial begin
        rst_n = 1;
        model_reset();
        #1 rst_n = 0;
        step();
        step();
        check("rst_outs", 32'(dut_outs()), 32'd0);
        rst_n = 1;

        // ring, beep cadence, stop
        sw_alarm_enable = 1;
        step();
        check("armed", 32'(alarm_enable), 32'd1);
        alarm_on = 1;
        step();
        check("ring_on", 32'(ringing), 32'd1);
        check("buz_entry", 32'(buzzer), 32'd1);
        for (int i = 1; i <= 10; i++) begin
            tick_10hz = 1;
            step();
            check("beep", 32'(buzzer), 32'((i % 10) < 5));
        end
        btn_stop = 1;
        step();
        check("stop_clr", 32'(alarm_clear), 32'd1);
        check("stop_buz", 32'(buzzer), 32'd0);
        alarm_on = 0;
        step();
        check("clr_1cyc", 32'(alarm_clear), 32'd0);

        // snooze twice, third snooze stops
        alarm_on = 1;
        step();
        for (int k = 0; k < 2; k++) begin
            btn_snooze = 1;
            step();
            alarm_on = 0;
            check("snz_on", 32'(snoozing), 32'd1);
            check("snz_left", 32'(snooze_left), 32'(SNZ));
            for (int i = 0; i < SNZ; i++) begin
                tick_1hz = 1;
                step();
            end
            check("snz_back", 32'(ringing), 32'd1);
            check("snz_left0", 32'(snooze_left), 32'd0);
        end
        btn_snooze = 1;
        step();
        check("snz_max", 32'({alarm_enable, ringing, snoozing}), 32'b100);
        check("snz_max_clr", 32'(alarm_clear), 32'd1);

        // timeout
        alarm_on = 1;
        step();
        alarm_on = 0;
        for (int i = 1; i <= TMO; i++) begin
            tick_1hz = 1;
            step();
        end
        check("tmo", 32'({ringing, alarm_clear}), 32'b01);

        // stop and snooze together
        alarm_on = 1;
        step();
        alarm_on = 0;
        btn_stop = 1;
        btn_snooze = 1;
        step();
        check("stop_wins", 32'({alarm_enable, ringing, snoozing}), 32'b100);

        // set min auto-repeat
        set_mode = 1;
        btn_set_min = 1;
        cnt = 0;
        step();
        cnt += int'(inc_alarm_min);
        for (int i = 0; i < 8; i++) begin
            step();
            cnt += int'(inc_alarm_min);
            tick_10hz = 1;
            step();
            cnt += int'(inc_alarm_min);
        end
        step();
        cnt += int'(inc_alarm_min);
        check("rep_cnt", 32'(cnt), 32'd4);
        btn_set_min = 0;
        step();

        // set hour ignored while ringing
        alarm_on = 1;
        step();
        alarm_on = 0;
        btn_set_hour = 1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick_10hz = 1;
            step();
            cnt += int'(inc_alarm_hour);
        end
        btn_stop = 1;
        step();
        cnt += int'(inc_alarm_hour);
        step();
        cnt += int'(inc_alarm_hour);
        check("ring_noset", 32'(cnt), 32'd0);
        btn_set_hour = 0;
        set_mode = 0;
        step();

        // reset mid-snooze
        alarm_on = 1;
        step();
        btn_snooze = 1;
        step();
        alarm_on = 0;
        tick_1hz = 1;
        step();
        check("pre_rst_left", 32'(snooze_left), 32'd2);
        async_reset();
        step();
        check("post_rst", 32'({alarm_enable, snoozing}), 32'b10);
        check("post_rst_left", 32'(snooze_left), 32'd0);

        // random
        for (int n = 0; n < 4000; n++) begin
            tick_1hz = ($urandom % 6) == 0;
            tick_10hz = ($urandom % 3) == 0;
            btn_stop = ($urandom % 40) == 0;
            btn_snooze = ($urandom % 12) == 0;
            sw_alarm_enable = ($urandom % 150) != 0;
            if (m_clr) alarm_on = 0;
            else if (!alarm_on && ($urandom % 25) == 0) alarm_on = 1;
            if (($urandom % 60) == 0) set_mode = ~set_mode;
            if (($urandom % 8) == 0) btn_set_hour = ~btn_set_hour;
            if (($urandom % 9) == 0) btn_set_min = ~btn_set_min;
            if (($urandom % 700) == 0) async_reset();
            else step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameters (name, default, meaning): SNOOZE_SEC, 300, snooze length in tick_1hz ticks; RING_TIMEOUT_SEC, 60, auto-stop after ringing this many ticks; MAX_SNOOZE, 3, snoozes allowed per alarm event; REPEAT_DLY, 5, tick_10hz ticks before auto-repeat starts.
REQ-002 clk  in  1  single system clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 tick_1hz  in  1  one-cycle pulse per second from the timebase.
REQ-005 tick_10hz  in  1  one-cycle pulse per 100 ms from the timebase.
REQ-006 sw_alarm_enable  in  1  level, user enables the alarm.
REQ-007 alarm_on  in  1  level, latched match flag from the alarm time/compare block.
REQ-008 btn_snooze, btn_stop  in  1 each  debounced one-cycle pulses.
REQ-009 set_mode  in  1  level, alarm-time setting mode.
REQ-010 btn_set_hour, btn_set_min  in  1 each  debounced levels, high while held.
REQ-011 alarm_enable  out  1  enable to the compare block; high in ARMED, RINGING, SNOOZE.
REQ-012 alarm_clear  out  1  one-cycle pulse clearing alarm_on in the compare block.
REQ-013 inc_alarm_hour, inc_alarm_min  out  1 each  one-cycle increment pulses.
REQ-014 buzzer  out  1  registered buzzer drive.
REQ-015 ringing, snoozing  out  1 each  status levels for display.
REQ-016 snooze_left  out  9  seconds of snooze remaining; 0 outside SNOOZE.

Function
REQ-017 FSM states: IDLE, ARMED, RINGING, SNOOZE.
REQ-018 Any state, sw_alarm_enable low -> IDLE next cycle; alarm_clear pulses if leaving RINGING or SNOOZE.
REQ-019 IDLE, sw_alarm_enable high -> ARMED next cycle.
REQ-020 ARMED, alarm_on high -> RINGING next cycle; ring timer and beep counter zeroed on entry.
REQ-021 RINGING, btn_stop -> ARMED, alarm_clear pulse, snooze count zeroed.
REQ-022 RINGING, btn_snooze with snooze count < MAX_SNOOZE -> SNOOZE, alarm_clear pulse, snooze count +1, snooze_left loaded with SNOOZE_SEC.
REQ-023 RINGING, btn_snooze with snooze count == MAX_SNOOZE -> treated as btn_stop.
REQ-024 btn_stop and btn_snooze same cycle -> stop wins.
REQ-025 RINGING, ring timer reaches RING_TIMEOUT_SEC tick_1hz ticks -> treated as btn_stop.
REQ-026 SNOOZE: snooze_left decrements on each tick_1hz; tick at snooze_left==1 -> RINGING next cycle, snooze_left 0.
REQ-027 SNOOZE, btn_stop -> ARMED, snooze count zeroed; btn_snooze ignored; alarm_on ignored.
REQ-028 buzzer high only in RINGING: on for 5 tick_10hz ticks, off for 5, repeating, starting on at RINGING entry; low in every other state within one cycle.
REQ-029 alarm_clear is exactly one cycle per qualifying transition, asserted the cycle after the transition decision.
REQ-030 Set: only when set_mode high and state != RINGING; hour and min channels independent, may pulse same cycle.
REQ-031 Set channel: rising edge of held button -> one inc pulse next cycle; if still held after REPEAT_DLY tick_10hz ticks, one pulse per further tick_10hz; release or set_mode low stops repeat and zeroes the delay counter.
REQ-032 Entering RINGING while a set button is held cancels the repeat; re-press required.

Reset
REQ-033 rst_n low: state IDLE, all counters zero, all outputs 0, regardless of current state or in-progress snooze/repeat.
REQ-034 rst_n deassertion takes effect at the next rising clk; no output pulse generated by reset release.

Structure
REQ-035 Shared package clock_pkg holds FSM state encodings and the default parameter values for SNOOZE_SEC, RING_TIMEOUT_SEC, MAX_SNOOZE, REPEAT_DLY.
REQ-036 One sub-module btn_autorepeat (edge detect + delay counter + repeat), instantiated twice (hour, min).
REQ-037 All outputs registered; no combinational path input-to-output.

Verification (sim params SNOOZE_SEC=3, RING_TIMEOUT_SEC=5, MAX_SNOOZE=2, REPEAT_DLY=5)
REQ-038 Enable high, alarm_on high -> ringing=1 next cycle, buzzer on 5 tick_10hz ticks then off 5; btn_stop -> ARMED, single alarm_clear pulse, buzzer 0.
REQ-039 Ring, btn_snooze -> snoozing=1, snooze_left=3; after 3 tick_1hz ticks -> ringing=1; repeat snooze once; third btn_snooze -> ARMED, clear pulse.
REQ-040 Ring with no buttons -> after 5 tick_1hz ticks ARMED, alarm_clear pulse, snooze count 0.
REQ-041 btn_stop and btn_snooze same cycle in RINGING -> ARMED, snoozing stays 0.
REQ-042 set_mode=1, hold btn_set_min for 8 tick_10hz ticks -> 1 immediate pulse + 3 repeat pulses (ticks 6,7,8); btn_set_hour during RINGING -> no pulses.
REQ-043 rst_n low mid-SNOOZE (snooze_left=2) -> all outputs 0, IDLE; after release with enable high -> ARMED, snooze_left 0.
